// File: rtl/gpu_regfile_arb.sv
// Port scheduler and power-on clearing sweep for the 64x32 dual-port GPU register file.
// Four requesters share the two RAM ports; port controls are driven combinationally from this cycle's grants.
module gpu_regfile_arb (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        wb0_valid,
    input  logic [5:0]  wb0_addr,
    input  logic [31:0] wb0_data,
    input  logic        wb1_valid,
    input  logic [5:0]  wb1_addr,
    input  logic [31:0] wb1_data,
    output logic        wb1_ready,
    input  logic        rd_valid,
    input  logic [5:0]  rd_addr0,
    input  logic [5:0]  rd_addr1,
    output logic        rd_ready,
    output logic        rd_dval,
    output logic [31:0] rd_d0,
    output logic [31:0] rd_d1,
    input  logic        hst_valid,
    input  logic        hst_we,
    input  logic [5:0]  hst_addr,
    input  logic [31:0] hst_wdata,
    output logic        hst_ready,
    output logic        hst_rvalid,
    output logic [31:0] hst_rdata,
    output logic        init_busy,
    output logic        nwea,
    output logic        clka,
    output logic [5:0]  aa,
    output logic [31:0] da,
    output logic        nweb,
    output logic        clkb,
    output logic [5:0]  ab,
    output logic [31:0] db,
    input  logic [31:0] qa,
    input  logic [31:0] qb
);

    logic       r_init_busy;
    logic [4:0] r_sweep_k;
    logic [1:0] r_hst_wait;
    logic       r_rd_pend;
    logic       r_hrd_pend;

    logic w_active;
    logic w_sweep;
    logic w_wb0;
    logic w_hst_ok;
    logic w_g_hst_pri;
    logic w_g_wb1;
    logic w_g_rd;
    logic w_g_hst;

    assign w_active = ~reset & ~r_init_busy;
    assign w_sweep  = ~reset & r_init_busy;
    assign w_wb0    = w_active & wb0_valid;

    // Host and wb1 are held off any address wb0 is writing this cycle.
    assign w_hst_ok    = w_active & hst_valid & ~(wb0_valid & (hst_addr == wb0_addr));
    assign w_g_hst_pri = w_hst_ok & (r_hst_wait == 2'd3);
    assign w_g_wb1     = w_active & wb1_valid & ~(wb0_valid & (wb1_addr == wb0_addr)) & ~w_g_hst_pri;
    assign w_g_rd      = w_active & rd_valid & ~wb0_valid & ~w_g_hst_pri & ~w_g_wb1;
    assign w_g_hst     = w_g_hst_pri | (w_hst_ok & ~w_g_wb1 & ~w_g_rd);

    assign wb1_ready  = w_g_wb1;
    assign rd_ready   = w_g_rd;
    assign hst_ready  = w_g_hst;
    assign init_busy  = r_init_busy | reset;
    assign rd_dval    = r_rd_pend & ~reset;
    assign hst_rvalid = r_hrd_pend & ~reset;
    assign rd_d0      = qa;
    assign rd_d1      = qb;
    assign hst_rdata  = qb;

    always_comb begin
        clka = 1'b0;
        nwea = 1'b1;
        aa   = '0;
        da   = '0;
        if (w_sweep) begin
            clka = 1'b1;
            nwea = 1'b0;
            aa   = {r_sweep_k, 1'b0};
        end else if (w_wb0) begin
            clka = 1'b1;
            nwea = 1'b0;
            aa   = wb0_addr;
            da   = wb0_data;
        end else if (w_g_rd) begin
            clka = 1'b1;
            aa   = rd_addr0;
        end
    end

    always_comb begin
        clkb = 1'b0;
        nweb = 1'b1;
        ab   = '0;
        db   = '0;
        if (w_sweep) begin
            clkb = 1'b1;
            nweb = 1'b0;
            ab   = {r_sweep_k, 1'b1};
        end else if (w_g_wb1) begin
            clkb = 1'b1;
            nweb = 1'b0;
            ab   = wb1_addr;
            db   = wb1_data;
        end else if (w_g_hst) begin
            clkb = 1'b1;
            nweb = ~hst_we;
            ab   = hst_addr;
            db   = hst_wdata;
        end else if (w_g_rd) begin
            clkb = 1'b1;
            ab   = rd_addr1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_init_busy <= 1'b1;
            r_sweep_k   <= '0;
            r_hst_wait  <= '0;
            r_rd_pend   <= 1'b0;
            r_hrd_pend  <= 1'b0;
        end else begin
            if (r_init_busy) begin
                r_sweep_k <= r_sweep_k + 5'd1;
                if (r_sweep_k == 5'd31)
                    r_init_busy <= 1'b0;
            end
            r_rd_pend  <= w_g_rd;
            r_hrd_pend <= w_g_hst & ~hst_we;
            if (hst_valid & ~w_g_hst)
                r_hst_wait <= (r_hst_wait == 2'd3) ? 2'd3 : r_hst_wait + 2'd1;
            else
                r_hst_wait <= '0;
        end
    end

endmodule

// File: tb/tb_gpu_regfile_arb.sv
// Randomised bench for gpu_regfile_arb: a behavioural RAM plus a cycle-level reference
// model of grants, port drive, clearing sweep and read return.
module tb_gpu_regfile_arb;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        wb0_valid, wb1_valid, rd_valid, hst_valid, hst_we;
    logic [5:0]  wb0_addr, wb1_addr, rd_addr0, rd_addr1, hst_addr;
    logic [31:0] wb0_data, wb1_data, hst_wdata;
    logic        wb1_ready, rd_ready, rd_dval, hst_ready, hst_rvalid, init_busy;
    logic [31:0] rd_d0, rd_d1, hst_rdata;
    logic        nwea, clka, nweb, clkb;
    logic [5:0]  aa, ab;
    logic [31:0] da, db, qa, qb;

    always #5 sys_clk = ~sys_clk;

    gpu_regfile_arb dut (
        .sys_clk(sys_clk), .reset(reset),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .rd_valid(rd_valid), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_ready(rd_ready),
        .rd_dval(rd_dval), .rd_d0(rd_d0), .rd_d1(rd_d1),
        .hst_valid(hst_valid), .hst_we(hst_we), .hst_addr(hst_addr), .hst_wdata(hst_wdata),
        .hst_ready(hst_ready), .hst_rvalid(hst_rvalid), .hst_rdata(hst_rdata),
        .init_busy(init_busy),
        .nwea(nwea), .clka(clka), .aa(aa), .da(da),
        .nweb(nweb), .clkb(clkb), .ab(ab), .db(db),
        .qa(qa), .qb(qb)
    );

    // rd64x32: registered read, old data on a same-cycle write
    logic [31:0] ram [64];
    always @(posedge sys_clk) begin
        if (clka) begin
            if (!nwea) ram[aa] <= da;
            qa <= ram[aa];
        end
        if (clkb) begin
            if (!nweb) ram[ab] <= db;
            qb <= ram[ab];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    bit          m_busy = 1'b1;
    int          m_k = 0;
    int          m_wait = 0;
    bit          m_prd = 1'b0, m_phst = 1'b0;
    logic [31:0] m_pd0, m_pd1, m_ph;
    logic [31:0] m_mem [64];

    task automatic idle();
        wb0_valid = 0; wb1_valid = 0; rd_valid = 0; hst_valid = 0; hst_we = 0;
    endtask

    // Called just after a falling edge with inputs applied; checks this cycle and advances the model.
    task automatic step();
        bit gh, g1, gr, hok;
        #1;
        check_eq("rd_dval", rd_dval, reset ? 1'b0 : m_prd);
        check_eq("hst_rvalid", hst_rvalid, reset ? 1'b0 : m_phst);
        if (!reset && m_prd) begin
            check_eq("rd_d0", rd_d0, m_pd0);
            check_eq("rd_d1", rd_d1, m_pd1);
        end
        if (!reset && m_phst) check_eq("hst_rdata", hst_rdata, m_ph);
        gh = 0; g1 = 0; gr = 0;
        if (reset || m_busy) begin
            check_eq("init_busy", init_busy, 1'b1);
            check_eq("readies", {wb1_ready, rd_ready, hst_ready}, 3'b000);
        end
        if (reset) begin
            check_eq("idle_ports", {clka, nwea, clkb, nweb}, 4'b0101);
            m_busy = 1; m_k = 0; m_wait = 0;
        end else if (m_busy) begin
            check_eq("sweep_ports", {clka, nwea, clkb, nweb}, 4'b1010);
            check_eq("sweep_aa", aa, 2 * m_k);
            check_eq("sweep_ab", ab, 2 * m_k + 1);
            check_eq("sweep_data", {da, db}, 64'd0);
            m_mem[2 * m_k] = 0;
            m_mem[2 * m_k + 1] = 0;
            m_k++;
            if (m_k == 32) m_busy = 0;
        end else begin
            // priority: wb0, starved host, wb1, rd, host; rd needs both ports alone
            hok = hst_valid && !(wb0_valid && hst_addr == wb0_addr);
            if (m_wait == 3 && hok) gh = 1;
            if (!gh && wb1_valid && !(wb0_valid && wb1_addr == wb0_addr)) g1 = 1;
            if (!gh && !g1 && rd_valid && !wb0_valid) gr = 1;
            if (!gh && !g1 && !gr && hok) gh = 1;
            check_eq("init_busy", init_busy, 1'b0);
            check_eq("wb1_ready", wb1_ready, g1);
            check_eq("rd_ready", rd_ready, gr);
            check_eq("hst_ready", hst_ready, gh);
            check_eq("porta_ctl", {clka, nwea}, {wb0_valid | gr, ~wb0_valid});
            check_eq("portb_ctl", {clkb, nweb}, {g1 | gh | gr, ~(g1 | (gh & hst_we))});
            if (wb0_valid) begin
                check_eq("wb0_aa", aa, wb0_addr);
                check_eq("wb0_da", da, wb0_data);
            end
            if (gr) check_eq("rd_addrs", {aa, ab}, {rd_addr0, rd_addr1});
            if (g1) check_eq("wb1_bus", {ab, db}, {wb1_addr, wb1_data});
            if (gh) check_eq("hst_ab", ab, hst_addr);
            if (gh && hst_we) check_eq("hst_db", db, hst_wdata);
        end
        // read return of next cycle comes from state before this cycle's writes
        m_prd = !reset && gr;
        m_pd0 = m_mem[rd_addr0];
        m_pd1 = m_mem[rd_addr1];
        m_phst = !reset && gh && !hst_we;
        m_ph = m_mem[hst_addr];
        if (!reset && !m_busy) begin
            if (wb0_valid) m_mem[wb0_addr] = wb0_data;
            if (g1) m_mem[wb1_addr] = wb1_data;
            if (gh && hst_we) m_mem[hst_addr] = hst_wdata;
        end
        if (!reset) m_wait = (hst_valid && !gh) ? ((m_wait < 3) ? m_wait + 1 : 3) : 0;
        @(negedge sys_clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic host_rd(input logic [5:0] a);
        idle(); hst_valid = 1; hst_addr = a; step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i] = $urandom;
            m_mem[i] = 32'hDEAD_BEEF;
        end
        reset = 1; idle();
        wb0_addr = 0; wb0_data = 0; wb1_addr = 0; wb1_data = 0;
        rd_addr0 = 0; rd_addr1 = 0; hst_addr = 0; hst_wdata = 0;
        @(negedge sys_clk);
        steps(3);
        reset = 0;
        steps(32);
        host_rd(0); host_rd(31); host_rd(63);
        idle(); step();

        // parallel wb0/wb1 then a dual read
        wb0_valid = 1; wb0_addr = 5; wb0_data = 32'h1111_1111;
        wb1_valid = 1; wb1_addr = 9; wb1_data = 32'h2222_2222; step();
        idle(); rd_valid = 1; rd_addr0 = 5; rd_addr1 = 9; step();
        idle(); step();

        // same-address wb0/wb1 hazard
        wb0_valid = 1; wb0_addr = 7; wb0_data = 32'hAAAA_0007;
        wb1_valid = 1; wb1_addr = 7; wb1_data = 32'hBBBB_0007; step();
        wb0_valid = 0; step();
        idle(); rd_valid = 1; rd_addr0 = 7; rd_addr1 = 7; step();
        idle(); step();

        // host starvation behind continuous wb1
        hst_valid = 1; hst_we = 0; hst_addr = 3;
        wb1_valid = 1; wb1_addr = 20; wb1_data = 32'h3333_0020;
        steps(4);
        hst_valid = 0; step();
        idle(); step();

        // rd blocked by wb0
        rd_valid = 1; rd_addr0 = 20; rd_addr1 = 5;
        wb0_valid = 1; wb0_addr = 40; wb0_data = 32'h4444_0040;
        steps(3);
        wb0_valid = 0; step();
        idle(); step();

        // reset pulse mid-sweep with a host read outstanding
        reset = 1; step(); reset = 0;
        host_rd(12); steps(9);
        reset = 1; step(); reset = 0;
        steps(33);
        idle(); step();

        for (int c = 0; c < 4000; c++) begin
            bit narrow;
            narrow = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 599) == 0);
            wb0_valid = ($urandom_range(0, 2) == 0);
            wb1_valid = ($urandom_range(0, 2) == 0);
            rd_valid  = ($urandom_range(0, 1) == 0);
            hst_valid = ($urandom_range(0, 2) == 0);
            hst_we    = $urandom_range(0, 1);
            wb0_addr  = narrow ? 6'($urandom_range(0, 7)) : 6'($urandom);
            wb1_addr  = narrow ? 6'($urandom_range(0, 7)) : 6'($urandom);
            hst_addr  = narrow ? 6'($urandom_range(0, 7)) : 6'($urandom);
            rd_addr0  = narrow ? 6'($urandom_range(0, 7)) : 6'($urandom);
            rd_addr1  = narrow ? 6'($urandom_range(0, 7)) : 6'($urandom);
            wb0_data  = $urandom; wb1_data = $urandom; hst_wdata = $urandom;
            step();
        end
        reset = 0; idle(); steps(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
